// File: rtl/wb_arbiter_pkg.sv
// Shared arbitration-mode codes and FSM state type for the Wishbone bus arbiter.
package wb_arbiter_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } arb_state_t;

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational priority picker: first set request searching upward from base (RR) or from 0 (fixed).
// Zero latency; the winner is only a candidate, the caller decides whether to register it.
module wb_arb_pick
  import wb_arbiter_pkg::*;
#(
  parameter int N    = 3,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] base,
  input  logic            mode,
  output logic [N-1:0]    gnt,
  output logic            vld
);

  int idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(mode) == ARB_RR) ? (int'(base) + i) % N : i;
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// N-master Wishbone arbiter: registered one-hot grant (1-cycle latency), bus locked while owner holds cyc.
// Slave side mirrors the owner combinationally; a stalled strobe is cut off by the watchdog with an error.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = DATA_W / 8,
  parameter int ROUND_ROBIN = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_MASTERS-1:0]        i_m_cyc,
  input  logic [NUM_MASTERS-1:0]        i_m_we,
  input  logic [NUM_MASTERS*SEL_W-1:0]  i_m_stb,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_m_dat,
  output logic [DATA_W-1:0]             o_m_dat,
  output logic [NUM_MASTERS-1:0]        o_m_ack,
  output logic [NUM_MASTERS-1:0]        o_m_err,
  output logic                          o_wb_cyc,
  output logic [SEL_W-1:0]              o_wb_stb,
  output logic                          o_wb_we,
  output logic [ADDR_W-1:0]             o_wb_addr,
  output logic [DATA_W-1:0]             o_wb_dat,
  input  logic [DATA_W-1:0]             i_wb_dat,
  input  logic                          i_wb_ack,
  input  logic                          i_wb_err,
  output logic [NUM_MASTERS-1:0]        o_grant,
  output logic                          o_timeout
);

  localparam int IDXW = $clog2(NUM_MASTERS);
  localparam int WDW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [IDXW-1:0]        last_winner, last_nxt;
  logic [WDW-1:0]         wd_cnt, wd_nxt;

  logic [IDXW-1:0]        owner, rr_base, pick_idx;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_vld;
  logic                   owner_cyc;
  logic [SEL_W-1:0]       owner_stb;
  logic                   expire;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (o_grant[i]) owner = IDXW'(i);
  end

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (pick_gnt[i]) pick_idx = IDXW'(i);
  end

  assign rr_base = (last_winner == IDXW'(NUM_MASTERS - 1)) ? '0 : last_winner + 1'b1;

  wb_arb_pick #(
    .N    (NUM_MASTERS),
    .IDXW (IDXW)
  ) u_pick (
    .req  (i_m_cyc),
    .base (rr_base),
    .mode (ROUND_ROBIN == ARB_RR),
    .gnt  (pick_gnt),
    .vld  (pick_vld)
  );

  assign owner_cyc = i_m_cyc[owner];
  assign owner_stb = i_m_stb[owner*SEL_W +: SEL_W];
  assign expire    = (TIMEOUT != 0) && (state == ST_OWNED) && (int'(wd_cnt) == TIMEOUT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      o_grant     <= '0;
      last_winner <= IDXW'(NUM_MASTERS - 1);
      wd_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      o_grant     <= grant_nxt;
      last_winner <= last_nxt;
      wd_cnt      <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = o_grant;
    last_nxt  = last_winner;
    wd_nxt    = wd_cnt;
    case (state)
      ST_IDLE: begin
        wd_nxt = '0;
        if (pick_vld) begin
          state_nxt = ST_OWNED;
          grant_nxt = pick_gnt;
          last_nxt  = pick_idx;
        end
      end
      ST_OWNED: begin
        if (expire || !owner_cyc) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          wd_nxt    = '0;
        end else if (i_wb_ack || i_wb_err) begin
          wd_nxt = '0;
        end else if ((TIMEOUT != 0) && (owner_stb != '0)) begin
          wd_nxt = wd_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        wd_nxt    = '0;
      end
    endcase
  end

  // On expiry the slave is cut off and a late ack is swallowed; only the error reaches the owner.
  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = '0;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_dat  = '0;
    o_m_ack   = '0;
    o_m_err   = '0;
    o_timeout = expire;
    o_m_dat   = i_wb_dat;
    if (state == ST_OWNED) begin
      o_wb_we   = i_m_we[owner];
      o_wb_addr = i_m_addr[owner*ADDR_W +: ADDR_W];
      o_wb_dat  = i_m_dat[owner*DATA_W +: DATA_W];
      if (expire) begin
        o_m_err = o_grant;
      end else begin
        o_wb_cyc = owner_cyc;
        o_wb_stb = owner_stb;
        if (i_wb_err)
          o_m_err = o_grant;
        else if (i_wb_ack)
          o_m_ack = o_grant;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a fixed-priority and a round-robin instance share one stimulus stream.
module tb_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    m_cyc, m_we;
  logic [N*SW-1:0] m_stb;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_dat;
  logic [DW-1:0]   wb_rdat;
  logic            wb_ack, wb_err;

  logic [DW-1:0] f_mdat, r_mdat;
  logic [N-1:0]  f_ack, r_ack, f_err, r_err, f_grant, r_grant;
  logic          f_cyc, r_cyc, f_we, r_we, f_to, r_to;
  logic [SW-1:0] f_stb, r_stb;
  logic [AW-1:0] f_addr, r_addr;
  logic [DW-1:0] f_wdat, r_wdat;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW),
               .ROUND_ROBIN(0), .TIMEOUT(4)) dut_fp (
    .i_clk(clk), .i_reset(rst),
    .i_m_cyc(m_cyc), .i_m_we(m_we), .i_m_stb(m_stb), .i_m_addr(m_addr), .i_m_dat(m_dat),
    .o_m_dat(f_mdat), .o_m_ack(f_ack), .o_m_err(f_err),
    .o_wb_cyc(f_cyc), .o_wb_stb(f_stb), .o_wb_we(f_we), .o_wb_addr(f_addr), .o_wb_dat(f_wdat),
    .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .o_grant(f_grant), .o_timeout(f_to)
  );

  wb_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW),
               .ROUND_ROBIN(1), .TIMEOUT(4)) dut_rr (
    .i_clk(clk), .i_reset(rst),
    .i_m_cyc(m_cyc), .i_m_we(m_we), .i_m_stb(m_stb), .i_m_addr(m_addr), .i_m_dat(m_dat),
    .o_m_dat(r_mdat), .o_m_ack(r_ack), .o_m_err(r_err),
    .o_wb_cyc(r_cyc), .o_wb_stb(r_stb), .o_wb_we(r_we), .o_wb_addr(r_addr), .o_wb_dat(r_wdat),
    .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .o_grant(r_grant), .o_timeout(r_to)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Master write data is the inverted address so routing of both buses shows up in one check.
  task automatic drv(input int k, input logic cyc, input logic [SW-1:0] stb, input logic [AW-1:0] addr);
    m_cyc[k]           = cyc;
    m_stb[k*SW +: SW]  = stb;
    m_addr[k*AW +: AW] = addr;
    m_dat[k*DW +: DW]  = ~addr;
  endtask

  task automatic do_reset;
    rst     = 1'b1;
    m_cyc   = '0;
    m_we    = '0;
    m_stb   = '0;
    m_addr  = '0;
    m_dat   = '0;
    wb_rdat = '0;
    wb_ack  = 1'b0;
    wb_err  = 1'b0;
    nxt;
    nxt;
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset;
    smp;
    chk("rst_grant_f", f_grant, 0);
    chk("rst_grant_r", r_grant, 0);
    chk("rst_cyc_f",   f_cyc, 0);
    chk("rst_addr_f",  f_addr, 0);
    chk("rst_to_f",    f_to, 0);
    chk("rst_ack_f",   f_ack, 0);
    chk("rst_err_f",   f_err, 0);

    // single master 1 read, then write-path routing
    nxt; drv(1, 1'b1, 4'hF, 32'h100); m_we = 3'b010;
    smp; chk("t1_lat_grant", f_grant, 0); chk("t1_lat_cyc", f_cyc, 0);
    nxt;
    smp; chk("t1_grant", f_grant, 3'b010); chk("t1_cyc", f_cyc, 1); chk("t1_addr", f_addr, 32'h100);
         chk("t1_we", f_we, 1); chk("t1_wdat", f_wdat, 32'hFFFF_FEFF); chk("t1_stb", f_stb, 4'hF);
         chk("t1_noack", f_ack, 0);
    nxt; wb_ack = 1'b1; wb_rdat = 32'hDEAD_BEEF;
    smp; chk("t1_ack", f_ack, 3'b010); chk("t1_rdat", f_mdat, 32'hDEAD_BEEF); chk("t1_err", f_err, 0);
    nxt; wb_ack = 1'b0; drv(1, 1'b0, 4'h0, 32'h0); m_we = '0;
    smp; chk("t1_ack_off", f_ack, 0); chk("t1_cyc_drop", f_cyc, 0); chk("t1_grant_hold", f_grant, 3'b010);
    nxt;
    smp; chk("t1_release", f_grant, 0); chk("t1_idle_addr", f_addr, 0);

    // fixed priority with bus lock
    do_reset;
    nxt; drv(0, 1'b1, 4'h0, 32'h200); drv(1, 1'b1, 4'h0, 32'h300); drv(2, 1'b1, 4'h0, 32'h400);
    smp; chk("fp_lat", f_grant, 0);
    nxt;
    smp; chk("fp_g0", f_grant, 3'b001); chk("fp_addr0", f_addr, 32'h200);
    nxt; wb_ack = 1'b1;
    smp; chk("fp_lock", f_grant, 3'b001); chk("fp_ack_route", f_ack, 3'b001);
    nxt; wb_ack = 1'b0; drv(0, 1'b0, 4'h0, 32'h0);
    smp; chk("fp_drop_grant", f_grant, 3'b001); chk("fp_drop_cyc", f_cyc, 0);
    nxt;
    smp; chk("fp_gap", f_grant, 0); chk("fp_gap_cyc", f_cyc, 0);
    nxt;
    smp; chk("fp_g1", f_grant, 3'b010); chk("fp_addr1", f_addr, 32'h300); chk("fp_cyc1", f_cyc, 1);

    // round-robin: each master drops after one ack, re-requests during the idle cycle
    do_reset;
    nxt; drv(0, 1'b1, 4'hF, 32'h10); drv(1, 1'b1, 4'hF, 32'h20); drv(2, 1'b1, 4'hF, 32'h30);
    smp; chk("rr_lat", r_grant, 0);
    nxt; wb_ack = 1'b1;
    smp; chk("rr_g0", r_grant, 3'b001); chk("rr_ack0", r_ack, 3'b001); chk("rr_addr0", r_addr, 32'h10);
    nxt; wb_ack = 1'b0; drv(0, 1'b0, 4'h0, 32'h0);
    smp; chk("rr_hold0", r_grant, 3'b001); chk("rr_cyc_drop0", r_cyc, 0);
    nxt; drv(0, 1'b1, 4'hF, 32'h10);
    smp; chk("rr_gap0", r_grant, 0);
    nxt; wb_ack = 1'b1;
    smp; chk("rr_g1", r_grant, 3'b010); chk("rr_ack1", r_ack, 3'b010);
    nxt; wb_ack = 1'b0; drv(1, 1'b0, 4'h0, 32'h0);
    smp;
    nxt; drv(1, 1'b1, 4'hF, 32'h20);
    smp; chk("rr_gap1", r_grant, 0);
    nxt; wb_ack = 1'b1;
    smp; chk("rr_g2", r_grant, 3'b100); chk("rr_ack2", r_ack, 3'b100); chk("rr_addr2", r_addr, 32'h30);
    nxt; wb_ack = 1'b0; drv(2, 1'b0, 4'h0, 32'h0);
    smp;
    nxt; drv(2, 1'b1, 4'hF, 32'h30);
    smp; chk("rr_gap2", r_grant, 0);
    nxt;
    smp; chk("rr_wrap_g0", r_grant, 3'b001);

    // watchdog, TIMEOUT = 4; a late ack in the expiry cycle must be dropped
    do_reset;
    nxt; drv(2, 1'b1, 4'hF, 32'h500);
    smp; chk("to_lat", f_grant, 0);
    nxt;
    smp; chk("to_grant", f_grant, 3'b100); chk("to_idle0", f_to, 0);
    for (int i = 0; i < 3; i++) begin
      nxt;
      smp; chk("to_stall", f_to, 0);
    end
    nxt; wb_ack = 1'b1;
    smp; chk("to_pulse", f_to, 1); chk("to_err", f_err, 3'b100); chk("to_ack_drop", f_ack, 0);
         chk("to_cyc_cut", f_cyc, 0); chk("to_stb_cut", f_stb, 0);
    nxt; wb_ack = 1'b0; drv(2, 1'b0, 4'h0, 32'h0);
    smp; chk("to_grant_clr", f_grant, 0); chk("to_pulse_end", f_to, 0); chk("to_err_end", f_err, 0);

    // error takes priority over ack
    do_reset;
    nxt; drv(0, 1'b1, 4'hF, 32'h600);
    smp;
    nxt;
    smp; chk("ep_grant", f_grant, 3'b001);
    nxt; wb_ack = 1'b1; wb_err = 1'b1;
    smp; chk("ep_err", f_err, 3'b001); chk("ep_ack", f_ack, 0);
    nxt; wb_ack = 1'b0; wb_err = 1'b0; drv(0, 1'b0, 4'h0, 32'h0);

    // reset mid-burst; last_winner must return to N-1 so master 0 beats master 1
    do_reset;
    nxt; drv(0, 1'b1, 4'h0, 32'h700);
    smp;
    nxt;
    smp; chk("mr_grant", r_grant, 3'b001); chk("mr_cyc", r_cyc, 1);
    rst = 1'b1;
    nxt; wb_ack = 1'b1;
    smp; chk("mr_grant_clr", r_grant, 0); chk("mr_cyc_clr", r_cyc, 0); chk("mr_no_ack", r_ack, 0);
    nxt; wb_ack = 1'b0; rst = 1'b0; drv(1, 1'b1, 4'h0, 32'h800);
    smp; chk("mr_idle", r_grant, 0);
    nxt;
    smp; chk("mr_first_m0", r_grant, 3'b001); chk("mr_addr", r_addr, 32'h700);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
